// File: rtl/multisim_push_arb_pkg.sv
// Shared types and helpers for the multisim push arbiter.
// The statistics counters are built only when MULTISIM_PUSH_ARB_STATS_EN is defined.
package multisim_push_arb_pkg;

  localparam int STAT_WIDTH = 32;
  localparam int PACK_MAX_W = 256;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Compare before incrementing, so no value ever reaches n. This holds for any n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Places the tag directly above the payload. The caller narrows the result to its own width.
  function automatic logic [PACK_MAX_W-1:0] pack_word(input logic [PACK_MAX_W-1:0] tag,
                                                      input logic [PACK_MAX_W-1:0] payload,
                                                      input int unsigned data_width);
    return (tag << data_width) | payload;
  endfunction

endpackage

// File: rtl/multisim_rr_pick.sv
// Combinational round-robin picker. It returns the first active request at or after ptr.
// When it reaches the top index, the search wraps around to index 0.
module multisim_rr_pick
  import multisim_push_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                grant_vld,
  output logic [ID_WIDTH-1:0] grant_id
);

  int idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin arbiter that merges NUM_REQ producers into one tagged push channel.
// Define MULTISIM_PUSH_ARB_STATS_EN to enable the grant and stall counters. Otherwise those ports read 0.
module multisim_push_arbiter
  import multisim_push_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int OUT_WIDTH  = DATA_WIDTH + ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [NUM_REQ*32-1:0]         stat_grants,
  output logic [31:0]                   stat_stall
);

  // Handshake: a word moves on any edge where valid and ready are both high. Valid never waits on ready.
  out_state_e            state_q, state_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  grant_vld;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  load_ok;
  logic                  load;

  multisim_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_vld),
    .ptr       (ptr_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  assign out_vld  = (state_q == OUT_FULL);
  assign out_data = out_data_q;

  always_comb begin
    load_ok    = (state_q == OUT_EMPTY) || out_rdy;
    load       = rst_n && grant_vld && load_ok;
    req_rdy    = '0;
    state_d    = state_q;
    out_data_d = out_data_q;
    ptr_d      = ptr_q;
    // Gate with rst_n so that no handshake can complete while reset is held.
    if (rst_n && grant_vld) req_rdy[grant_id] = load_ok;
    if (load) begin
      state_d    = OUT_FULL;
      out_data_d = OUT_WIDTH'(pack_word(PACK_MAX_W'(grant_id),
                     PACK_MAX_W'(req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH]),
                     DATA_WIDTH));
      ptr_d      = ID_WIDTH'(rr_next(32'(grant_id), NUM_REQ));
    end else if (state_q == OUT_FULL && out_rdy) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OUT_EMPTY;
      out_data_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef MULTISIM_PUSH_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] grants_q [NUM_REQ];
  logic [STAT_WIDTH-1:0] grants_d [NUM_REQ];
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == OUT_FULL && !out_rdy && stall_q != '1) stall_d = stall_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      grants_d[i] = grants_q[i];
      if (load && grant_id == ID_WIDTH'(i) && grants_q[i] != '1)
        grants_d[i] = grants_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= grants_d[i];
    end
  end

  assign stat_stall = stall_q;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*32 +: 32] = grants_q[g];
  end
`else
  assign stat_grants = '0;
  assign stat_stall  = '0;
`endif

endmodule
